// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: captures bytes on rx_done into a
// 16-deep show-ahead FIFO drained by the processor read strobe, with status flags.
module uart_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_done,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              read,
  input  logic              reset_buffer,
  input  logic              clear_overrun,
  output logic [DATA_W-1:0] data_out,
  output logic              data_present,
  output logic              half_full,
  output logic              full,
  output logic              overrun,
  output logic [ADDR_W:0]   fill_level
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] HALF_LEVEL = (ADDR_W + 1)'(DEPTH / 2);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_fill_level;
  logic              r_overrun;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_empty = (r_fill_level == {(ADDR_W + 1){1'b0}});
  assign w_full  = r_fill_level[ADDR_W];
  // Flush overrides both ports; a pop on a full FIFO frees the slot for a same-cycle write.
  assign w_pop   = read & ~w_empty & ~reset_buffer;
  assign w_push  = rx_done & ~reset_buffer & (~w_full | w_pop);
  assign w_drop  = rx_done & ~reset_buffer & w_full & ~w_pop;

  // Character storage; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= rx_data;
    end
  end

  // Pointer and level bookkeeping with synchronous flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr     <= {ADDR_W{1'b0}};
      r_rd_ptr     <= {ADDR_W{1'b0}};
      r_fill_level <= {(ADDR_W + 1){1'b0}};
    end else if (reset_buffer) begin
      r_wr_ptr     <= {ADDR_W{1'b0}};
      r_rd_ptr     <= {ADDR_W{1'b0}};
      r_fill_level <= {(ADDR_W + 1){1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_fill_level <= r_fill_level + (ADDR_W + 1)'(1);
        2'b01:   r_fill_level <= r_fill_level - (ADDR_W + 1)'(1);
        default: r_fill_level <= r_fill_level;
      endcase
    end
  end

  // Sticky overrun: a new drop beats a same-cycle clear; flush leaves it alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (clear_overrun) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= r_overrun;
    end
  end

  assign data_out     = w_empty ? {DATA_W{1'b0}} : r_mem[r_rd_ptr];
  assign data_present = ~w_empty;
  assign full         = w_full;
  assign half_full    = (r_fill_level >= HALF_LEVEL);
  assign overrun      = r_overrun;
  assign fill_level   = r_fill_level;

endmodule
